// File: rtl/ctrl_pkg.sv
// Purpose: shared encodings for the multicycle MIPS control unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: FSM state encoding, opcodes, func_sel modes, pc_src codes,
// instruction class enum and the per-class ALU selector mapping.
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IF   = 3'd0,
    ST_ID   = 3'd1,
    ST_EX   = 3'd2,
    ST_MEM  = 3'd3,
    ST_WB   = 3'd4,
    ST_HALT = 3'd5
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_HALT = 6'b111111;

  localparam logic [1:0] SEL_FUNCT = 2'd0;
  localparam logic [1:0] SEL_ADD   = 2'd1;
  localparam logic [1:0] SEL_SUB   = 2'd2;
  localparam logic [1:0] SEL_OR    = 2'd3;

  localparam logic [1:0] PC_SRC_SEQ = 2'd0;
  localparam logic [1:0] PC_SRC_BR  = 2'd1;
  localparam logic [1:0] PC_SRC_JMP = 2'd2;

  typedef enum logic [2:0] {
    CL_R    = 3'd0,
    CL_J    = 3'd1,
    CL_BEQ  = 3'd2,
    CL_ADDI = 3'd3,
    CL_ORI  = 3'd4,
    CL_LW   = 3'd5,
    CL_SW   = 3'd6
  } class_t;

  // ALU selector mode used during EX for each instruction class.
  function automatic logic [1:0] class_func_sel(input class_t cls);
    logic [1:0] sel;
    sel = SEL_FUNCT;
    case (cls)
      CL_ADDI, CL_LW, CL_SW: sel = SEL_ADD;
      CL_BEQ:                sel = SEL_SUB;
      CL_ORI:                sel = SEL_OR;
      default:               sel = SEL_FUNCT;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Purpose: opcode to instruction-class decoder with stop flag.
// Latency: combinational, zero cycles.
// Backpressure: none.
// Ports: i_opcode (instr[31:26]) in; o_class (decoded class), o_illegal
// (halt opcode or any unsupported opcode: the FSM must stop) out.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [5:0] i_opcode,
  output class_t     o_class,
  output logic       o_illegal
);

  always_comb begin
    o_class   = CL_R;
    o_illegal = 1'b0;
    case (i_opcode)
      OP_R:    o_class = CL_R;
      OP_J:    o_class = CL_J;
      OP_BEQ:  o_class = CL_BEQ;
      OP_ADDI: o_class = CL_ADDI;
      OP_ORI:  o_class = CL_ORI;
      OP_LW:   o_class = CL_LW;
      OP_SW:   o_class = CL_SW;
      // The halt opcode is folded in with unsupported ones: both end in HALT.
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Purpose: multicycle MIPS control FSM (IF/ID/EX/MEM/WB/HALT) with retire counter.
// Latency: 3 cycles beq/j, 4 cycles R/addi/ori/sw, 5 cycles lw; outputs are Moore.
// Backpressure: none; the datapath is assumed to complete each step in one cycle.
// Ports: clk/rst (sync, active high); instr, zero in; datapath enables
// (ir_we, mem_re, mem_we, pc_we, rf_we), muxes (pc_src, rf_dst, wb_mem),
// ALU selector (func_code, func_sel), halted and instret out.
module mc_ctrl_fsm
  import ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr,
  input  logic             zero,
  output logic             ir_we,
  output logic             mem_re,
  output logic             mem_we,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic             rf_we,
  output logic             rf_dst,
  output logic             wb_mem,
  output logic [10:0]      func_code,
  output logic [1:0]       func_sel,
  output logic             halted,
  output logic [CNT_W-1:0] instret
);

  state_t           r_state;
  class_t           r_class;
  logic [CNT_W-1:0] r_instret;

  class_t w_dec_class;
  logic   w_dec_illegal;
  logic   w_retire;

  // Only opcode and shamt/funct are consumed here; register fields go to the datapath.
  logic   w_unused_instr;
  assign w_unused_instr = ^instr[25:11];

  ctrl_decode u_decode (
    .i_opcode  (instr[31:26]),
    .o_class   (w_dec_class),
    .o_illegal (w_dec_illegal)
  );

  // Retire on the edge that leaves the last state of each instruction class.
  always_comb begin
    w_retire = 1'b0;
    case (r_state)
      ST_EX:   w_retire = (r_class == CL_BEQ) || (r_class == CL_J);
      ST_MEM:  w_retire = (r_class == CL_SW);
      ST_WB:   w_retire = 1'b1;
      default: w_retire = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IF;
      r_class   <= CL_R;
      r_instret <= '0;
    end else begin
      case (r_state)
        ST_IF: r_state <= ST_ID;
        ST_ID: begin
          r_class <= w_dec_class;
          r_state <= w_dec_illegal ? ST_HALT : ST_EX;
        end
        ST_EX: begin
          case (r_class)
            CL_BEQ, CL_J: r_state <= ST_IF;
            CL_LW, CL_SW: r_state <= ST_MEM;
            default:      r_state <= ST_WB;
          endcase
        end
        ST_MEM:  r_state <= (r_class == CL_LW) ? ST_WB : ST_IF;
        ST_WB:   r_state <= ST_IF;
        ST_HALT: r_state <= ST_HALT;
        default: r_state <= ST_IF;
      endcase
      if (w_retire) begin
        r_instret <= r_instret + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign instret   = r_instret;
  assign func_code = instr[10:0];

  // Output decode from state and latched class. rst masks everything because
  // the state register only reaches IF after the first reset edge.
  always_comb begin
    ir_we    = 1'b0;
    mem_re   = 1'b0;
    mem_we   = 1'b0;
    pc_we    = 1'b0;
    pc_src   = PC_SRC_SEQ;
    rf_we    = 1'b0;
    rf_dst   = 1'b0;
    wb_mem   = 1'b0;
    func_sel = SEL_FUNCT;
    halted   = 1'b0;
    if (!rst) begin
      case (r_state)
        ST_IF: begin
          mem_re = 1'b1;
          ir_we  = 1'b1;
          pc_we  = 1'b1;
          pc_src = PC_SRC_SEQ;
        end
        ST_EX: begin
          func_sel = class_func_sel(r_class);
          if (r_class == CL_BEQ) begin
            // zero is live from the ALU this cycle; the PC captures on this edge.
            pc_we  = zero;
            pc_src = PC_SRC_BR;
          end else if (r_class == CL_J) begin
            pc_we  = 1'b1;
            pc_src = PC_SRC_JMP;
          end
        end
        ST_MEM: begin
          mem_re = (r_class == CL_LW);
          mem_we = (r_class == CL_SW);
        end
        ST_WB: begin
          rf_we  = 1'b1;
          rf_dst = (r_class == CL_R);
          wb_mem = (r_class == CL_LW);
        end
        ST_HALT: halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Purpose: scoreboard bench for mc_ctrl_fsm at CNT_W=32 and CNT_W=4.
// Latency: one expected entry per clock, compared on the falling edge.
// Backpressure: none.
module tb_mc_ctrl_fsm;

  localparam int PH_IF = 0, PH_ID = 1, PH_EX = 2, PH_MEM = 3, PH_WB = 4, PH_HALT = 5;

  typedef struct packed {
    logic        ir_we;
    logic        mem_re;
    logic        mem_we;
    logic        pc_we;
    logic [1:0]  pc_src;
    logic        rf_we;
    logic        rf_dst;
    logic        wb_mem;
    logic [1:0]  func_sel;
    logic        halted;
    logic [10:0] func_code;
  } ctl_t;

  typedef struct packed {
    ctl_t        ctl;
    logic [31:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        zero = 1'b0;
  logic [31:0] instr = 32'h0;

  logic        a_ir_we, a_mem_re, a_mem_we, a_pc_we, a_rf_we, a_rf_dst, a_wb_mem, a_halted;
  logic [1:0]  a_pc_src, a_func_sel;
  logic [10:0] a_func_code;
  logic [31:0] a_instret;
  logic        b_ir_we, b_mem_re, b_mem_we, b_pc_we, b_rf_we, b_rf_dst, b_wb_mem, b_halted;
  logic [1:0]  b_pc_src, b_func_sel;
  logic [10:0] b_func_code;
  logic [3:0]  b_instret;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [31:0] model_cnt = 32'h0;

  always #5 clk = ~clk;

  mc_ctrl_fsm #(.CNT_W(32)) u_dut32 (
    .clk(clk), .rst(rst), .instr(instr), .zero(zero),
    .ir_we(a_ir_we), .mem_re(a_mem_re), .mem_we(a_mem_we), .pc_we(a_pc_we),
    .pc_src(a_pc_src), .rf_we(a_rf_we), .rf_dst(a_rf_dst), .wb_mem(a_wb_mem),
    .func_code(a_func_code), .func_sel(a_func_sel), .halted(a_halted),
    .instret(a_instret)
  );

  mc_ctrl_fsm #(.CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .instr(instr), .zero(zero),
    .ir_we(b_ir_we), .mem_re(b_mem_re), .mem_we(b_mem_we), .pc_we(b_pc_we),
    .pc_src(b_pc_src), .rf_we(b_rf_we), .rf_dst(b_rf_dst), .wb_mem(b_wb_mem),
    .func_code(b_func_code), .func_sel(b_func_sel), .halted(b_halted),
    .instret(b_instret)
  );

  function automatic bit is_legal(input logic [5:0] op);
    return (op == 6'h00) || (op == 6'h02) || (op == 6'h04) || (op == 6'h08) ||
           (op == 6'h0D) || (op == 6'h23) || (op == 6'h2B);
  endfunction

  // Expected outputs for one cycle, from the instruction's current step.
  function automatic ctl_t expect_ctl(input int ph, input logic [5:0] op,
                                      input logic z, input logic [31:0] ins);
    ctl_t c;
    c = '0;
    c.func_code = ins[10:0];
    case (ph)
      PH_IF: begin
        c.ir_we = 1'b1; c.mem_re = 1'b1; c.pc_we = 1'b1; c.pc_src = 2'd0;
      end
      PH_EX: begin
        case (op)
          6'h00:               c.func_sel = 2'd0;
          6'h08, 6'h23, 6'h2B: c.func_sel = 2'd1;
          6'h0D:               c.func_sel = 2'd3;
          6'h04: begin c.func_sel = 2'd2; c.pc_we = z; c.pc_src = 2'd1; end
          6'h02: begin c.pc_we = 1'b1; c.pc_src = 2'd2; end
          default: ;
        endcase
      end
      PH_MEM: begin
        c.mem_re = (op == 6'h23);
        c.mem_we = (op == 6'h2B);
      end
      PH_WB: begin
        c.rf_we = 1'b1; c.rf_dst = (op == 6'h00); c.wb_mem = (op == 6'h23);
      end
      PH_HALT: c.halted = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

  // Drive one clock of stimulus and queue what the DUT must show in that cycle.
  task automatic drive_cycle(input bit r, input int ph, input logic [31:0] ins, input int zf);
    exp_t e;
    @(posedge clk);
    #1;
    rst   = r;
    instr = ins;
    zero  = (zf < 0) ? 1'($urandom_range(1, 0)) : 1'(zf);
    if (r) begin
      e.ctl = '0;
      e.ctl.func_code = ins[10:0];
    end else begin
      e.ctl = expect_ctl(ph, ins[31:26], zero, ins);
    end
    e.cnt = model_cnt;
    exp_q.push_back(e);
    if (r) model_cnt = 32'h0;
  endtask

  task automatic do_reset(input int n, input logic [31:0] ins);
    for (int k = 0; k < n; k++) drive_cycle(1'b1, PH_IF, ins, -1);
  endtask

  // Run one instruction; abort_at replaces that step with a reset pulse.
  task automatic run_instr(input logic [31:0] ins, input int zf, input int abort_at,
                           input int halt_cycles);
    logic [5:0] op;
    int ph[$];
    op = ins[31:26];
    ph.push_back(PH_IF);
    ph.push_back(PH_ID);
    if (!is_legal(op)) begin
      for (int k = 0; k < halt_cycles; k++) ph.push_back(PH_HALT);
    end else begin
      ph.push_back(PH_EX);
      if (op == 6'h23 || op == 6'h2B) ph.push_back(PH_MEM);
      if (op != 6'h04 && op != 6'h02 && op != 6'h2B) ph.push_back(PH_WB);
    end
    for (int i = 0; i < ph.size(); i++) begin
      if (i == abort_at) begin
        do_reset(1 + int'($urandom_range(1, 0)), ins);
        return;
      end
      drive_cycle(1'b0, ph[i], ins, zf);
    end
    if (is_legal(op)) model_cnt = model_cnt + 32'd1;
    else do_reset(1, ins);
  endtask

  always @(negedge clk) begin
    ctl_t act_a, act_b;
    exp_t e;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      act_a = {a_ir_we, a_mem_re, a_mem_we, a_pc_we, a_pc_src, a_rf_we, a_rf_dst,
               a_wb_mem, a_func_sel, a_halted, a_func_code};
      act_b = {b_ir_we, b_mem_re, b_mem_we, b_pc_we, b_pc_src, b_rf_we, b_rf_dst,
               b_wb_mem, b_func_sel, b_halted, b_func_code};
      checks++;
      if (act_a !== e.ctl) begin
        errors++;
        $display("FAIL ctl32 cyc=%0d got=%h want=%h", cyc, act_a, e.ctl);
      end
      checks++;
      if (act_b !== e.ctl) begin
        errors++;
        $display("FAIL ctl4 cyc=%0d got=%h want=%h", cyc, act_b, e.ctl);
      end
      checks++;
      if (a_instret !== e.cnt) begin
        errors++;
        $display("FAIL instret32 cyc=%0d got=%0d want=%0d", cyc, a_instret, e.cnt);
      end
      checks++;
      if (b_instret !== e.cnt[3:0]) begin
        errors++;
        $display("FAIL instret4 cyc=%0d got=%0d want=%0d", cyc, b_instret, e.cnt[3:0]);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [5:0]  ops[9];
    logic [31:0] ins;
    int          budget;
    ops = '{6'h00, 6'h02, 6'h04, 6'h08, 6'h0D, 6'h23, 6'h2B, 6'h3F, 6'h3E};

    // Counters are undefined until the first reset edge: hold reset unchecked.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    model_cnt = 32'h0;
    do_reset(1, 32'h0);

    // Directed sequences.
    run_instr(32'h012A4020, -1, -1, 0);         // R add
    run_instr(32'h8D090004, -1, -1, 0);         // lw
    run_instr(32'h11090003, 1, -1, 0);          // beq taken
    run_instr(32'h11090003, 0, -1, 0);          // beq not taken
    run_instr(32'hFC000000, -1, -1, 20);        // halt opcode
    run_instr(32'hF8001234, -1, -1, 20);        // unsupported opcode
    run_instr(32'h21280007, -1, -1, 0);         // addi
    run_instr(32'h3528FFFF, -1, -1, 0);         // ori
    run_instr(32'hAD090008, -1, PH_MEM, 0);     // sw aborted in MEM

    // 4-bit counter wrap: 16 retires, then observe one IF before resetting.
    do_reset(1, 32'h0);
    for (int k = 0; k < 16; k++) run_instr(32'h08000010 | k, -1, -1, 0);
    run_instr(32'h08000000, -1, 1, 0);

    // Random instruction stream with occasional aborts and halts.
    for (int n = 0; n < 300; n++) begin
      ins = $urandom;
      if ($urandom_range(19, 0) < 17) ins[31:26] = ops[$urandom_range(6, 0)];
      else ins[31:26] = ops[$urandom_range(8, 7)];
      run_instr(ins, -1,
                ($urandom_range(9, 0) == 0) ? int'($urandom_range(4, 0)) : -1,
                1 + int'($urandom_range(4, 0)));
    end

    budget = 20;
    while (exp_q.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_ctrl_fsm.md
# mc_ctrl_fsm

Multicycle control unit for the MIPS datapath. Fetches each instruction through five Moore states and decodes opcode and funct. It drives the function-selector block with `func_code` and `func_sel`, so the ALU function comes from the R-type funct field or from a fixed per-opcode choice. It also drives every datapath write and memory enable and keeps a retired-instruction counter.

## Interface
Parameters:
- `CNT_W`, 32: width of the retired-instruction counter.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `instr`  in  32  instruction register contents, stable from ID onward.
- `zero`  in  1  ALU zero flag, sampled in EX.
- `ir_we`  out  1  instruction register write.
- `mem_re`  out  1  memory read.
- `mem_we`  out  1  memory write.
- `pc_we`  out  1  PC write.
- `pc_src`  out  2  PC source: 0 = PC+4, 1 = branch target, 2 = jump target.
- `rf_we`  out  1  register-file write.
- `rf_dst`  out  1  register-file destination: 1 = rd, 0 = rt.
- `wb_mem`  out  1  write-back data: 1 = memory data, 0 = ALU result.
- `func_code`  out  11  equals `instr[10:0]` (shamt and funct); goes to the selector's `func` input.
- `func_sel`  out  2  selector mode: 0 = R-type funct, 1 = ADD, 2 = SUB, 3 = OR.
- `halted`  out  1  high while in HALT.
- `instret`  out  CNT_W  retired-instruction count.

## Operation
- States and encoding: IF 0, ID 1, EX 2, MEM 3, WB 4, HALT 5.
- IF: `mem_re`=1, `ir_we`=1, `pc_we`=1, `pc_src`=0. Next state ID.
- ID: decode `instr[31:26]` and latch the result into a class register.
  - Supported opcodes: R 000000, j 000010, beq 000100, addi 001000, ori 001101, lw 100011, sw 101011, halt 111111.
  - halt or any unlisted opcode: go to HALT, no retire.
  - Otherwise: go to EX.
- EX: `func_sel` set by class: R 0, addi/lw/sw 1, beq 2, ori 3.
  - beq: `pc_we`=`zero`, `pc_src`=1; retire; go to IF.
  - j: `pc_we`=1, `pc_src`=2; retire; go to IF.
  - lw/sw: go to MEM.
  - R/addi/ori: go to WB.
- MEM:
  - lw: `mem_re`=1; go to WB.
  - sw: `mem_we`=1; retire; go to IF.
- WB: `rf_we`=1; `rf_dst`=1 only for R; `wb_mem`=1 only for lw; retire; go to IF.
- HALT: all enables 0, `halted`=1. Leave HALT only through `rst`.
- Retire: `instret` increments by 1 on the clock edge that leaves the final state of a completed instruction. It wraps modulo 2^CNT_W.
- In every state, enables not listed are 0, and `func_sel` is 0 outside EX.

## Timing
- While `rst` is high, on every clock the state goes to IF, the class register goes to R, and `instret` goes to 0. All enable outputs, `func_sel`, `pc_src` and `halted` are forced to 0.
- `rst` asserted in any state, including mid-instruction or HALT, aborts on the next edge. No retire occurs on that edge.
- First IF cycle is the first cycle after `rst` deasserts.
- All outputs are Moore: decoded from state plus the latched class. `func_code` is combinational from `instr`.
- Cycles per instruction: beq/j 3; R, addi, ori, sw 4; lw 5.
- `zero` is valid combinationally in EX. The beq decision uses its value at the EX clock edge.
- A branch taken and a retire on the same edge is normal behaviour.

## Structure
- Package `ctrl_pkg` holds:
  - state encodings;
  - opcode constants;
  - `func_sel` mode constants (SEL_FUNCT, SEL_ADD, SEL_SUB, SEL_OR);
  - `pc_src` codes;
  - the class enum.
- One sub-module, `ctrl_decode`: combinational mapping from opcode to class plus an illegal flag. It is instantiated once in ID-path logic.
- The top level holds the state register, class register, `instret` counter and output decode.

## Test plan
- Reset then R-type add (`instr`=0x012A4020): states IF, ID, EX, WB. In EX, `func_sel`=0 and `func_code`=0x020. In WB, `rf_we`=1 and `rf_dst`=1. `instret`=1 after 4 cycles.
- lw (0x8D090004): 5 cycles. EX `func_sel`=1. MEM `mem_re`=1. WB `rf_we`=1, `wb_mem`=1, `rf_dst`=0.
- beq with `zero`=1, then beq with `zero`=0: 3 cycles each. EX `func_sel`=2 both times. `pc_we`=1 with `pc_src`=1 only for the first. `instret` advances by 2.
- Opcode 0x3F, then opcode 0x3E: each goes to HALT after ID. `halted`=1 held for 20 cycles, all enables 0, `instret` unchanged.
- `rst` pulsed during MEM of sw: `mem_we` never asserts, next state IF, `instret`=0.
- Preload `instret` near wrap (CNT_W=4, 15 retires, then one more): count reads 0.
